mux_latch_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one 2:1 mux select and one set/clear output latch between channels A and B. It occupies a standard 8-in/8-out user-module slot and is clocked from the I/O bus. It sequences grant, capture, hold and release through a 4-state FSM, with a programmable hold length. It replaces the free-running cross-coupled NAND latch with a registered, arbitrated equivalent.

---
 rtl/mux_latch_arbiter_pkg.sv | 17 +
 rtl/mux_latch_arbiter_if.sv | 11 +
 rtl/mux_latch_arbiter_rr_arb2.sv | 25 ++
 rtl/mux_latch_arbiter.sv | 130 +++++++++++++
 tb/tb_mux_latch_arbiter.sv | 139 +++++++++++++
 5 files changed

// File: rtl/mux_latch_arbiter_pkg.sv
// Shared definitions for the two-channel mux/latch arbiter:
// state encoding, counter width and channel indices.
package mla_pkg;

    localparam int HOLD_W = 3;

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_HOLD    = 2'b10,
        ST_RELEASE = 2'b11
    } state_t;

endpackage

// File: rtl/mux_latch_arbiter_if.sv
// The 8-in/8-out user-module slot seen as one bundle; clk and rst_n ride
// in io_in[1:0] because the slot has no separate clock or reset pins.
interface mla_if;

    logic [7:0] io_in;
    logic [7:0] io_out;

    modport slave  (input io_in,  output io_out);
    modport master (output io_in, input io_out);

endinterface

// File: rtl/mux_latch_arbiter_rr_arb2.sv
// Combinational two-way round-robin picker; on a tie the channel that did
// not win last time is chosen.
module rr_arb2
    import mla_pkg::*;
(
    input  logic i_reqA,
    input  logic i_reqB,
    input  logic i_last,
    output logic o_valid,
    output logic o_winner,
    output logic o_contention
);

    always_comb begin
        o_valid      = i_reqA | i_reqB;
        o_contention = i_reqA & i_reqB;
        o_winner     = CH_A;
        if (i_reqA && i_reqB) begin
            o_winner = ~i_last;
        end else if (i_reqB) begin
            o_winner = CH_B;
        end
    end

endmodule

// File: rtl/mux_latch_arbiter.sv
// Registered, arbitrated replacement for a cross-coupled NAND latch: two
// requesters share one mux select and one set/clear latch via a 4-state FSM.
module mux_latch_arbiter
    import mla_pkg::*;
#(
    parameter int HOLD_CYCLES = 4
)
(
    mla_if.slave bus
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    logic w_clk;
    logic w_rstN;
    logic w_reqA;
    logic w_reqB;
    logic w_dataA;
    logic w_dataB;
    logic w_clr;
    logic w_mode;

    assign w_clk   = bus.io_in[0];
    assign w_rstN  = bus.io_in[1];
    assign w_reqA  = bus.io_in[2];
    assign w_reqB  = bus.io_in[3];
    assign w_dataA = bus.io_in[4];
    assign w_dataB = bus.io_in[5];
    assign w_clr   = bus.io_in[6];
    assign w_mode  = bus.io_in[7];

    state_t            r_state;
    state_t            w_nextState;
    logic              r_gntA;
    logic              r_gntB;
    logic              r_sel;
    logic              r_q;
    logic              r_busy;
    logic              r_last;
    logic              r_contention;
    logic              r_modeR;
    logic [HOLD_W-1:0] r_count;

    logic w_valid;
    logic w_winner;
    logic w_contention;
    logic w_grantedReq;
    logic w_arbPoint;
    logic w_holdDone;

    rr_arb2 u_arb (
        .i_reqA       (w_reqA),
        .i_reqB       (w_reqB),
        .i_last       (r_last),
        .o_valid      (w_valid),
        .o_winner     (w_winner),
        .o_contention (w_contention)
    );

    assign w_grantedReq = r_sel ? w_reqB : w_reqA;
    assign w_holdDone   = r_modeR ? ~w_grantedReq : (r_count == '0);
    // The closing edge of RELEASE is also an arbitration point, so a
    // continuously requesting pair re-grants every HOLD_CYCLES+2 cycles.
    assign w_arbPoint   = (r_state == ST_IDLE) || (r_state == ST_RELEASE);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE, ST_RELEASE: w_nextState = w_valid ? ST_GRANT : ST_IDLE;
            ST_GRANT:            w_nextState = ST_HOLD;
            ST_HOLD:             w_nextState = w_holdDone ? ST_RELEASE : ST_HOLD;
            default:             w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge w_clk) begin
        if (!w_rstN) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge w_clk) begin
        if (!w_rstN) begin
            r_gntA       <= 1'b0;
            r_gntB       <= 1'b0;
            r_sel        <= 1'b0;
            r_q          <= 1'b0;
            r_busy       <= 1'b0;
            r_last       <= 1'b1;
            r_contention <= 1'b0;
            r_modeR      <= 1'b0;
            r_count      <= '0;
        end else begin
            r_contention <= 1'b0;
            r_busy       <= (w_nextState != ST_IDLE);

            if (w_arbPoint && w_valid) begin
                r_gntA       <= (w_winner == CH_A);
                r_gntB       <= (w_winner == CH_B);
                r_sel        <= w_winner;
                r_last       <= w_winner;
                r_modeR      <= w_mode;
                r_contention <= w_contention;
                r_count      <= HOLD_LOAD;
            end

            if (r_state == ST_HOLD) begin
                if (!r_modeR && r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end
                if (w_holdDone) begin
                    r_gntA <= 1'b0;
                    r_gntB <= 1'b0;
                end
            end

            // clr wins over the capture in the GRANT cycle.
            if (w_clr) begin
                r_q <= 1'b0;
            end else if (r_state == ST_GRANT) begin
                r_q <= r_sel ? w_dataB : w_dataA;
            end
        end
    end

    assign bus.io_out = {r_contention, r_last, r_busy, ~r_q, r_q, r_sel, r_gntB, r_gntA};

endmodule

// File: tb/tb_mux_latch_arbiter.sv
// Directed plus random bench for mux_latch_arbiter, compared every cycle
// against a transaction-age model of the arbiter.
module tb_mux_latch_arbiter;

    localparam int H = 4;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic reqA = 1'b0;
    logic reqB = 1'b0;
    logic dataA = 1'b0;
    logic dataB = 1'b0;
    logic clr = 1'b0;
    logic mode = 1'b0;

    mla_if bus ();
    assign bus.io_in = {mode, clr, dataB, dataA, reqB, reqA, rstN, clk};

    mux_latch_arbiter #(.HOLD_CYCLES(H)) dut (.bus(bus));

    always #5 clk = ~clk;

    // Model: mAge counts cycles since the grant edge (-1 = idle); mEnd is the
    // age at which the RELEASE cycle sits (-1 = not yet known in mode 1).
    int   mAge = -1;
    int   mEnd = -1;
    logic mOwner = 1'b0;
    logic mLast = 1'b1;
    logic mSel = 1'b0;
    logic mQ = 1'b0;
    logic mCont = 1'b0;
    logic mMode = 1'b0;

    int nChecks = 0;
    int nFails = 0;

    task automatic modelEdge();
        logic newQ;
        logic arb;
        logic ownReq;
        if (!rstN) begin
            mAge = -1; mEnd = -1; mOwner = 1'b0; mLast = 1'b1;
            mSel = 1'b0; mQ = 1'b0; mCont = 1'b0; mMode = 1'b0;
        end else begin
            newQ = clr ? 1'b0 : ((mAge == 0) ? (mOwner ? dataB : dataA) : mQ);
            arb = (mAge < 0) || (mEnd >= 0 && mAge == mEnd);
            ownReq = mOwner ? reqB : reqA;
            mCont = 1'b0;
            if (arb) begin
                if (reqA || reqB) begin
                    mOwner = (reqA && reqB) ? ~mLast : reqB;
                    mLast = mOwner;
                    mSel = mOwner;
                    mMode = mode;
                    mCont = reqA && reqB;
                    mAge = 0;
                    mEnd = mode ? -1 : H + 1;
                end else begin
                    mAge = -1;
                    mEnd = -1;
                end
            end else begin
                if (mMode && mEnd < 0 && mAge >= 1 && !ownReq) mEnd = mAge + 1;
                mAge++;
            end
            mQ = newQ;
        end
    endtask

    task automatic applyStimulus(input logic rn, input logic ra, input logic rb,
                                 input logic da, input logic db, input logic c,
                                 input logic m);
        rstN = rn; reqA = ra; reqB = rb; dataA = da; dataB = db; clr = c; mode = m;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag);
        logic       gnt;
        logic [7:0] expOut;
        gnt = (mAge >= 0) && (mEnd < 0 || mAge < mEnd);
        expOut = {mCont, mLast, (mAge >= 0), ~mQ, mQ, mSel, gnt & mOwner, gnt & ~mOwner};
        nChecks++;
        assert (bus.io_out === expOut) else begin
            nFails++;
            $error("[TB] FAIL %s io_out=%b expected=%b", tag, bus.io_out, expOut);
        end
    endtask

    task automatic step(input string tag, input logic rn, input logic ra, input logic rb,
                        input logic da, input logic db, input logic c, input logic m);
        applyStimulus(rn, ra, rb, da, db, c, m);
        checkOutput(tag);
    endtask

    initial begin
        @(negedge clk);
        // reset, then idle with all inputs low
        step("reset0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("reset1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // single A request, mode 0, request dropped after grant
        step("soloA_grant", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step("soloA_hold", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // both requesting continuously: alternation and contention pulses
        for (int i = 0; i < 20; i++)
            step("tie_alt", 1'b1, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("tie_drain", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // mode 1: B requests for grant plus 3 cycles, then drops
        for (int i = 0; i < 4; i++) step("mode1_req", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("mode1_drop", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        // clr coincident with GRANT cycle keeps q low
        step("clr_grant0", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("clr_grant1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("clr_after", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // reset in the middle of HOLD, then a lone B request
        step("midrst_grant", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("midrst_hold", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("midrst_reset", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("midrst_reqB", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step("midrst_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // random traffic with occasional clr and rare reset
        for (int i = 0; i < 600; i++)
            step("random", ($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
